// File: rtl/fixed_float_conversion.sv
// rtl/fixed_float_conversion.sv - sign-magnitude Q1.20 fixed point to IEEE-754 single converter
// Normalizes by shifting left one bit per cycle; the exponent is derived from the shift count.
module fixed_float_conversion (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [21:0] data,
   output logic [31:0] result,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic        zero_q, zero_d;
   logic [20:0] mag_q, mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         mag_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         zero_q   <= zero_d;
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      zero_d   = zero_q;
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               sign_d  = data[21];
               mag_d   = data[20:0];
               cnt_d   = 5'd0;
               zero_d  = (data[20:0] == 21'd0);
               state_d = (data[20:0] == 21'd0) ? OUT : NORM;
            end
         end
         NORM: begin
            // mag is nonzero here, so the loop ends within 20 shifts
            if (mag_q[20]) begin
               state_d = OUT;
            end else begin
               mag_d = {mag_q[19:0], 1'b0};
               cnt_d = cnt_q + 5'd1;
            end
         end
         OUT: begin
            // zero input always yields +0, the sign is dropped
            result_d = zero_q ? 32'h0000_0000
                              : {sign_q, 8'd127 - {3'b000, cnt_q}, mag_q[19:0], 3'b000};
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fixed_float_conversion.sv
// tb/tb_fixed_float_conversion.sv - self-checking bench for fixed_float_conversion
module tb_fixed_float_conversion;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [21:0] data;
   logic [31:0] result;
   logic        done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   fixed_float_conversion dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .data   (data),
      .result (result),
      .done   (done),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: real-valued operand encoded as double, then narrowed to single precision.
   function automatic logic [31:0] ref_float(input logic [21:0] d, output int lat);
      real         v;
      logic [63:0] b;
      int          e11;
      if (d[20:0] == 21'd0) begin
         lat = 1;
         return 32'h0000_0000;
      end
      v = real'(d[20:0]) / 1048576.0;
      if (d[21]) v = -v;
      b   = $realtobits(v);
      e11 = int'(b[62:52]);
      lat = 1023 - e11 + 2;
      return {b[63], 8'(e11 - 1023 + 127), b[51:29]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int max, output int cycles);
      cycles = -1;
      for (int i = 1; i <= max; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cycles = i;
            return;
         end
      end
   endtask

   task automatic convert(input logic [21:0] d, input string tag);
      logic [31:0] exp_r;
      int          lat;
      int          c;
      exp_r = ref_float(d, lat);
      @(negedge clk);
      data   = d;
      enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      data   = 22'($urandom);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(40, c);
      check({tag, "_lat"}, 32'(c), 32'(lat));
      check({tag, "_res"}, result, exp_r);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [21:0] ops[4];
      logic [31:0] hold_r;
      logic [31:0] exp_r;
      logic [21:0] d;
      int          lat;
      int          c;
      int          k;

      reset  = 1'b1;
      enable = 1'b0;
      data   = 22'h0;
      #1;
      check("rst_result", result, 32'h0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      convert(22'h100000, "one");
      check("one_const", result, 32'h3F80_0000);
      convert(22'h080000, "half");
      check("half_const", result, 32'h3F00_0000);
      convert(22'h2C0000, "neg075");
      check("neg075_const", result, 32'hBF40_0000);
      convert(22'h000001, "lsb");
      check("lsb_const", result, 32'h3580_0000);
      convert(22'h3FFFFF, "allones");
      check("allones_const", result, 32'hBFFF_FFF8);
      convert(22'h000000, "zero");
      convert(22'h200000, "negzero");
      check("negzero_const", result, 32'h0);

      convert(22'h0C0000, "hold_src");
      hold_r = result;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("hold_res", result, hold_r);
         check("hold_done", 32'(done), 32'd0);
      end

      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 21);
         d = 22'($urandom);
         if (k == 21) d[20:0] = 21'd0;
         else d[20:0] = (21'd1 << (20 - k)) | (d[20:0] & ((21'd1 << (20 - k)) - 21'd1));
         convert(d, "rand");
      end

      // enable during busy must be ignored
      @(negedge clk);
      data   = 22'h000001;
      enable = 1'b1;
      @(posedge clk);
      #1;
      data = 22'h100000;
      repeat (5) @(posedge clk);
      #1;
      enable = 1'b0;
      wait_done(40, c);
      check("busy_ign_lat", 32'(c), 32'd17);
      check("busy_ign_res", result, 32'h3580_0000);

      // enable held high: each done cycle is followed by a new sampling edge
      ops[0] = 22'h100000;
      ops[1] = 22'h000000;
      ops[2] = 22'h2C0000;
      ops[3] = 22'h000040;
      @(negedge clk);
      data   = ops[0];
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_r = ref_float(ops[i], lat);
         wait_done(40, c);
         check("b2b_gap", 32'(c), 32'(lat + 1));
         check("b2b_res", result, exp_r);
         if (i < 3) data = ops[i + 1];
         else enable = 1'b0;
      end
      @(posedge clk);
      #1;
      check("b2b_end_done", 32'(done), 32'd0);

      // reset mid-normalization discards the operand
      @(negedge clk);
      data   = 22'h000001;
      enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_result", result, 32'h0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_done(30, c);
      check("midrst_nodone", 32'(c), 32'hFFFF_FFFF);
      convert(22'h100000, "after_rst");
      check("after_rst_const", result, 32'h3F80_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fixed_float_conversion.md
FIXED_FLOAT_CONVERSION -- requirements
Module: fixed_float_conversion

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: enable  input  1  conversion request, sampled only in IDLE.
REQ-004 SHALL have port: data  input  22  fixed-point operand: [21] sign, [20] integer bit, [19:0] fraction; sign-magnitude, value = data[20:0] * 2^-20.
REQ-005 SHALL have port: result  output  32  IEEE-754 single-precision value, registered.
REQ-006 SHALL have port: done  output  1  one-cycle pulse: result updated this cycle.
REQ-007 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, NORM, OUT; reset state IDLE.
REQ-009 IDLE, enable=1 at edge: SHALL latch sign=data[21], mag=data[20:0], shift count=0.
REQ-009a At the same edge: next state OUT with zero flag set if mag==0, else NORM.
REQ-010 IDLE, enable=0: SHALL hold state; done=0; result unchanged.
REQ-011 NORM: if mag[20]==1, SHALL go to OUT.
REQ-011a NORM otherwise: SHALL shift mag left 1 (zero fill), increment count, stay in NORM.
REQ-012 Count SHALL be 5 bits; never exceeds 20 because mag is nonzero in NORM.
REQ-013 OUT, nonzero: SHALL register result = {sign, 8'd127 - count, mag[19:0], 3'b000}.
REQ-014 OUT, zero flag: SHALL register result = 32'h00000000; input sign discarded, no -0.
REQ-015 OUT: SHALL assert done for exactly one cycle, coincident with result update; next state IDLE.
REQ-016 Latency, sampling edge to done high: k+2 cycles for nonzero (k = leading zeros of data[20:0], 0..20); 1 cycle for zero.
REQ-017 enable SHALL be ignored while busy; data need not be held after the sampling edge.
REQ-018 Back-to-back: enable high in the IDLE cycle where done is high SHALL start a new conversion at that edge.
REQ-019 Output exponents SHALL lie in 107..127; no denormals, infinities or NaNs produced.
REQ-020 Conversion SHALL be exact; no rounding (21 significant bits fit in 24).
REQ-021 result SHALL hold its last value until the next OUT state.

Reset
REQ-022 reset high SHALL immediately force state IDLE, result=32'h0, done=0, busy=0, internal mag/count/sign/zero flag=0, regardless of clk.
REQ-023 Reset asserted mid-conversion SHALL discard the in-flight operand; no done pulse for it after release.
REQ-024 First enable sampled after reset deasserts SHALL be processed normally.

Verification
REQ-025 data=22'h100000 (1.0) -> result=32'h3F800000, done 2 cycles after sampling edge.
REQ-026 data=22'h080000 (0.5) -> 32'h3F000000, latency 3; data=22'h2C0000 (-0.75) -> 32'hBF400000, latency 3.
REQ-027 data=22'h000001 (2^-20) -> 32'h35800000, latency 22.
REQ-027a data=22'h3FFFFF -> 32'hBFFFFFF8, latency 2.
REQ-028 data=22'h000000 and 22'h200000 -> 32'h00000000, latency 1, one done pulse each.
REQ-029 Second enable with new data during busy -> ignored, result from first operand only.
REQ-029a Enable held high continuously -> conversions back-to-back per REQ-018.
REQ-030 reset pulsed during NORM of data=22'h000001 -> outputs zero at once; no done.
REQ-030a After reset release, data=22'h100000 -> 32'h3F800000 in 2 cycles.
